// File: rtl/level_pkg.sv
// rtl/level_pkg.sv - shared level constants, bar mapping table and peak state type
package level_pkg;

  localparam int LEVEL_MAX = 10;

  localparam logic [3:0] BAR_MAP [0:LEVEL_MAX] = '{
    4'd0, 4'd1, 4'd2, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd6, 4'd7, 4'd8
  };

  typedef enum logic [1:0] {
    TRACK,
    HOLD,
    DECAY
  } peak_state_e;

  function automatic logic [3:0] bar_count(input logic [3:0] lvl);
    if (lvl > 4'(LEVEL_MAX)) return BAR_MAP[LEVEL_MAX];
    return BAR_MAP[lvl];
  endfunction

endpackage

// File: rtl/level_tick_gen.sv
// rtl/level_tick_gen.sv - free-running sample tick divider, frozen while EN is low
module level_tick_gen #(
  parameter int SAMPLE_DIV = 500000
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic EN,
  output logic TICK
);

  localparam int CNT_W = $clog2(SAMPLE_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(SAMPLE_DIV - 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // TICK is registered, so it is armed one count early to line up with CNT_LAST.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (EN) begin
      cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      tick_d = (cnt_q == CNT_PRE);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign TICK = tick_q;

endmodule

// File: rtl/level_bar_driver.sv
// rtl/level_bar_driver.sv - averaged level bar with peak-hold/decay marker for an 8-LED display
module level_bar_driver
  import level_pkg::*;
#(
  parameter int SAMPLE_DIV  = 500000,
  parameter int HOLD_TICKS  = 50,
  parameter int DECAY_TICKS = 5
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       EN,
  input  logic [7:0] LEVEL,
  output logic [7:0] LED,
  output logic [3:0] SMOOTH,
  output logic [3:0] PEAK,
  output logic       TICK
);

  localparam int HOLD_W  = $clog2(HOLD_TICKS + 1);
  localparam int DECAY_W = $clog2(DECAY_TICKS + 1);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_TICKS);
  localparam logic [DECAY_W-1:0] DECAY_LOAD = DECAY_W'(DECAY_TICKS);

  logic              tick;
  logic              fire;
  logic [3:0]        lvl_in;
  logic [5:0]        sum;
  logic [3:0]        smooth_new;
  logic [3:0]        hist_q [4];
  logic [3:0]        hist_d [4];
  logic [3:0]        smooth_q, smooth_d;
  logic [3:0]        peak_q, peak_d;
  peak_state_e       state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [DECAY_W-1:0] decay_q, decay_d;
  logic [7:0]        led_q, led_d;
  logic [3:0]        bar_s, bar_p;
  logic [8:0]        bar_ones;
  logic [7:0]        marker;

  level_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick_gen (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .EN     (EN),
    .TICK   (tick)
  );

  assign fire   = tick && EN;
  assign lvl_in = (LEVEL > 8'(LEVEL_MAX)) ? 4'(LEVEL_MAX) : LEVEL[3:0];

  always_comb begin
    hist_d = hist_q;
    if (fire) begin
      hist_d[0] = lvl_in;
      hist_d[1] = hist_q[0];
      hist_d[2] = hist_q[1];
      hist_d[3] = hist_q[2];
    end
    sum        = 6'(hist_d[0]) + 6'(hist_d[1]) + 6'(hist_d[2]) + 6'(hist_d[3]);
    smooth_new = 4'(sum >> 2);
    smooth_d   = fire ? smooth_new : smooth_q;
  end

  // Peak tracker steps once per tick against the freshly averaged level.
  always_comb begin
    state_d = state_q;
    peak_d  = peak_q;
    hold_d  = hold_q;
    decay_d = decay_q;
    if (fire) begin
      if (smooth_new >= peak_q) begin
        peak_d  = smooth_new;
        hold_d  = HOLD_LOAD;
        state_d = HOLD;
      end else begin
        unique case (state_q)
          TRACK: peak_d = smooth_new;
          HOLD: begin
            if (hold_q <= HOLD_W'(1)) begin
              hold_d  = '0;
              decay_d = DECAY_LOAD;
              state_d = DECAY;
            end else begin
              hold_d = hold_q - HOLD_W'(1);
            end
          end
          DECAY: begin
            if (decay_q <= DECAY_W'(1)) begin
              decay_d = DECAY_LOAD;
              if ((peak_q - 4'd1) <= smooth_new) begin
                peak_d  = smooth_new;
                decay_d = '0;
                state_d = TRACK;
              end else begin
                peak_d = peak_q - 4'd1;
              end
            end else begin
              decay_d = decay_q - DECAY_W'(1);
            end
          end
          default: state_d = TRACK;
        endcase
      end
    end
  end

  always_comb begin
    bar_s    = bar_count(smooth_q);
    bar_p    = bar_count(peak_q);
    bar_ones = (9'd1 << bar_s) - 9'd1;
    marker   = (bar_p != 4'd0) ? (8'd1 << (bar_p - 4'd1)) : 8'd0;
    led_d    = EN ? ~(8'(bar_ones) | marker) : led_q;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      hist_q   <= '{default: '0};
      smooth_q <= '0;
      peak_q   <= '0;
      state_q  <= TRACK;
      hold_q   <= '0;
      decay_q  <= '0;
      led_q    <= 8'hFF;
    end else begin
      hist_q   <= hist_d;
      smooth_q <= smooth_d;
      peak_q   <= peak_d;
      state_q  <= state_d;
      hold_q   <= hold_d;
      decay_q  <= decay_d;
      led_q    <= led_d;
    end
  end

  assign LED    = led_q;
  assign SMOOTH = smooth_q;
  assign PEAK   = peak_q;
  assign TICK   = tick;

endmodule
